// File: rtl/display_mux_scan.sv
`default_nettype none
// ============================================================================
//  Module      : display_mux_scan
//  Description : N-digit time-multiplexed 7-segment driver. Captures a
//                packed nibble value into a shadow register, scans one digit
//                per refresh slot on a shared segment bus, and supports
//                BCD/hex decode, leading-zero blanking and output polarity.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_mux_scan #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   valor,
    input  logic                    carregar,
    input  logic                    modo_hex,
    input  logic                    apagar_zeros,
    output logic [6:0]              segmentos,
    output logic [N_DIGITS-1:0]     anodos
);

    // Counter widths never drop below one bit so degenerate builds stay legal.
    localparam int c_cnt_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_idx_w = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [c_cnt_w-1:0]  c_cnt_max   = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_idx_w-1:0]  c_idx_max   = c_idx_w'(N_DIGITS - 1);
    localparam logic [6:0]          c_seg_blank = 7'b1111111;
    localparam logic [6:0]          c_seg_reset = {7{ACTIVE_LOW}};
    localparam logic [N_DIGITS-1:0] c_an_reset  = {N_DIGITS{ACTIVE_LOW}};

    logic [4*N_DIGITS-1:0] r_shadow;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_idx_w-1:0]    r_idx;
    logic [6:0]            r_seg;
    logic [N_DIGITS-1:0]   r_an;

    logic [3:0]            w_nib [N_DIGITS];
    logic [N_DIGITS-1:0]   w_zero_from;
    logic [N_DIGITS-1:0]   w_onehot;
    logic [3:0]            w_sel_nib;
    logic                  w_sel_zero;
    logic                  w_blank;
    logic [6:0]            w_seg_low;

    // Decode table is kept in active-low form; polarity is applied at the
    // output register so blanking and inversion compose without special cases.
    function automatic logic [6:0] decode_low(input logic [3:0] nib, input logic hex);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = hex ? 7'b0001000 : 7'b0111111;
            4'hB:    pat = hex ? 7'b0000011 : 7'b0111111;
            4'hC:    pat = hex ? 7'b1000110 : 7'b0111111;
            4'hD:    pat = hex ? 7'b0100001 : 7'b0111111;
            4'hE:    pat = hex ? 7'b0000110 : 7'b0111111;
            default: pat = hex ? 7'b0001110 : 7'b0111111;
        endcase
        return pat;
    endfunction

    // Shadow register: captures the datapath value on every load strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else if (carregar) begin
            r_shadow <= valor;
        end
    end

    // Refresh timer and digit index: the index steps on the timer wrap edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == c_cnt_max) begin
            r_cnt <= '0;
            r_idx <= (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Split the shadow register into one nibble per digit.
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_nibble
            assign w_nib[gi] = r_shadow[4*gi +: 4];
        end
    endgenerate

    // w_zero_from[i] is set when nibble i and every higher nibble are zero.
    always_comb begin
        logic v_run;
        v_run       = 1'b1;
        w_zero_from = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            v_run          = v_run && (w_nib[i] == 4'h0);
            w_zero_from[i] = v_run;
        end
    end

    // Pick the nibble, zero flag and anode for the digit currently scanned.
    always_comb begin
        w_sel_nib  = 4'h0;
        w_sel_zero = 1'b0;
        w_onehot   = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_sel_nib   = w_nib[i];
                w_sel_zero  = w_zero_from[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    // Digit 0 is never blanked so an all-zero value still shows a single "0".
    assign w_blank   = apagar_zeros && (r_idx != '0) && w_sel_zero;
    assign w_seg_low = w_blank ? c_seg_blank : decode_low(w_sel_nib, modo_hex);

    // Output register: applies polarity to the segment pattern and anode select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= c_seg_reset;
            r_an  <= c_an_reset;
        end else begin
            r_seg <= ACTIVE_LOW ? w_seg_low : ~w_seg_low;
            r_an  <= ACTIVE_LOW ? ~w_onehot : w_onehot;
        end
    end

    assign segmentos = r_seg;
    assign anodos    = r_an;

endmodule
`default_nettype wire

// File: tb/tb_display_mux_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_mux_scan
//  Description : Directed bench for display_mux_scan (4 digits, 4-cycle
//                slots). An active-low and an active-high build share inputs;
//                a reference model pushes expected outputs into a scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_mux_scan;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b1;
    logic [15:0] valor        = 16'h0000;
    logic        carregar     = 1'b0;
    logic        modo_hex     = 1'b0;
    logic        apagar_zeros = 1'b0;

    logic [6:0]  seg_lo;
    logic [3:0]  an_lo;
    logic [6:0]  seg_hi;
    logic [3:0]  an_hi;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] an;
    } exp_t;

    exp_t        sb [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [15:0] m_shadow = 16'h0000;
    int          m_cnt    = 0;
    int          m_idx    = 0;

    display_mux_scan #(.N_DIGITS(N), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk          (clk),
        .rst_n        (rst_n),
        .valor        (valor),
        .carregar     (carregar),
        .modo_hex     (modo_hex),
        .apagar_zeros (apagar_zeros),
        .segmentos    (seg_lo),
        .anodos       (an_lo)
    );

    display_mux_scan #(.N_DIGITS(N), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk          (clk),
        .rst_n        (rst_n),
        .valor        (valor),
        .carregar     (carregar),
        .modo_hex     (modo_hex),
        .apagar_zeros (apagar_zeros),
        .segmentos    (seg_hi),
        .anodos       (an_hi)
    );

    always #5 clk = ~clk;

    // Reference glyphs, active-low, g..a.
    function automatic logic [6:0] glyph(input logic [3:0] d, input logic hex);
        case (d)
            4'd0:  return 7'b1000000;
            4'd1:  return 7'b1111001;
            4'd2:  return 7'b0100100;
            4'd3:  return 7'b0110000;
            4'd4:  return 7'b0011001;
            4'd5:  return 7'b0010010;
            4'd6:  return 7'b0000010;
            4'd7:  return 7'b1111000;
            4'd8:  return 7'b0000000;
            4'd9:  return 7'b0010000;
            4'd10: return hex ? 7'b0001000 : 7'b0111111;
            4'd11: return hex ? 7'b0000011 : 7'b0111111;
            4'd12: return hex ? 7'b1000110 : 7'b0111111;
            4'd13: return hex ? 7'b0100001 : 7'b0111111;
            4'd14: return hex ? 7'b0000110 : 7'b0111111;
            default: return hex ? 7'b0001110 : 7'b0111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [6:0] so, input logic [6:0] se,
                         input logic [3:0] ao, input logic [3:0] ae);
        n_checks++;
        assert (so === se) else begin
            n_fail++;
            $error("FAIL %s segmentos: observed %b expected %b", tag, so, se);
        end
        n_checks++;
        assert (ao === ae) else begin
            n_fail++;
            $error("FAIL %s anodos: observed %b expected %b", tag, ao, ae);
        end
    endtask

    // One clock edge: model predicts from pre-edge state, DUT is compared at negedge.
    task automatic step(input string tag);
        exp_t e;
        logic blank;
        @(posedge clk);
        e.an        = 4'b1111;
        e.an[m_idx] = 1'b0;
        blank = apagar_zeros && (m_idx > 0) && ((m_shadow >> (4 * m_idx)) == 16'h0000);
        e.seg = blank ? 7'b1111111 : glyph(m_shadow[4*m_idx +: 4], modo_hex);
        sb.push_back(e);
        if (carregar) m_shadow = valor;
        if (m_cnt == DIV - 1) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % N;
        end else begin
            m_cnt++;
        end
        @(negedge clk);
        e = sb.pop_front();
        check({tag, "/lo"}, seg_lo, e.seg, an_lo, e.an);
        check({tag, "/hi"}, seg_hi, ~e.seg, an_hi, ~e.an);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic load(input logic [15:0] v, input string tag);
        valor    = v;
        carregar = 1'b1;
        step(tag);
        carregar = 1'b0;
    endtask

    // Asserts reset between edges, checks the immediate all-off state, releases at a negedge.
    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check({tag, "/lo_async"}, seg_lo, 7'b1111111, an_lo, 4'b1111);
        check({tag, "/hi_async"}, seg_hi, 7'b0000000, an_hi, 4'b0000);
        repeat (2) begin
            @(negedge clk);
            check({tag, "/lo_hold"}, seg_lo, 7'b1111111, an_lo, 4'b1111);
            check({tag, "/hi_hold"}, seg_hi, 7'b0000000, an_hi, 4'b0000);
        end
        rst_n    = 1'b1;
        m_shadow = 16'h0000;
        m_cnt    = 0;
        m_idx    = 0;
        sb.delete();
    endtask

    initial begin
        @(negedge clk);
        pulse_reset("reset");
        run(17, "zero_scan");

        load(16'h1234, "load_1234");
        run(16, "bcd_1234");

        modo_hex = 1'b1;
        load(16'h00AF, "load_00af");
        run(16, "hex_00af");
        modo_hex = 1'b0;
        run(16, "bcd_00af");

        apagar_zeros = 1'b1;
        load(16'h0050, "load_0050");
        run(16, "blank_0050");
        load(16'h0000, "load_0000");
        run(16, "blank_0000");

        modo_hex = 1'b1;
        load(16'h0A00, "load_0a00");
        run(16, "blank_hex_0a00");

        carregar = 1'b1;
        for (int i = 0; i < 24; i++) begin
            valor        = 16'($urandom);
            modo_hex     = 1'($urandom);
            apagar_zeros = 1'($urandom);
            step("track");
        end
        carregar = 1'b0;
        run(8, "track_hold");

        modo_hex     = 1'b0;
        apagar_zeros = 1'b0;
        load(16'h9876, "load_9876");
        for (int i = 0; i < 20 && !(m_idx == 2 && m_cnt == 1); i++) step("to_digit2");
        check("on_digit2", seg_lo, 7'b0000000, an_lo, 4'b1011);
        pulse_reset("mid_reset");
        run(16, "post_reset");

        load(16'h0008, "load_0008");
        run(8, "pol_0008");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
